// File: rtl/tx_prbs_modulator.sv
// PRBS-10 symbol modulator: one 10-sample symbol per LFSR bit, one sample per trigger.
// Latency 1 clock trigger->sample; no backpressure, the sample trigger paces the output.
// Burst control: start from IDLE only, etx_en low aborts to IDLE, odone pulses once per complete burst.
module tx_prbs_modulator #(
    parameter logic signed [15:0] AMPLITUDE = 16'sd8192,
    parameter int unsigned        SEQ_BITS  = 1023,
    parameter logic [9:0]         LFSR_SEED = 10'h3FF
) (
    input  logic               ctx_clk,
    input  logic               rtx_rst_n,
    input  logic               etx_en,
    input  logic               istart,
    input  logic               inew_sample_trig,
    output logic signed [15:0] osample,
    output logic               osample_valid,
    output logic               obit,
    output logic [3:0]         osample_order,
    output logic               obusy,
    output logic               odone
);

    // An all-zero seed would lock the LFSR up.
    localparam logic [9:0] SEED     = (LFSR_SEED == 10'h000) ? 10'h001 : LFSR_SEED;
    localparam logic [9:0] LAST_BIT = 10'(SEQ_BITS - 1);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t             state_q, state_d;
    logic [9:0]         lfsr_q, lfsr_d;
    logic [9:0]         bit_cnt_q, bit_cnt_d;
    logic [3:0]         order_q, order_d;
    logic signed [15:0] sample_q, sample_d;
    logic               valid_q, valid_d;
    logic               bit_q, bit_d;
    logic [3:0]         sorder_q, sorder_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic signed [15:0] sym_val;

    // Symbol shape: negative lobe at 2..4, positive lobe at 7..9, sign flipped for bit 0.
    always_comb begin
        sym_val = 16'sd0;
        case (order_q)
            4'd2, 4'd3, 4'd4: sym_val = lfsr_q[9] ? -AMPLITUDE : AMPLITUDE;
            4'd7, 4'd8, 4'd9: sym_val = lfsr_q[9] ? AMPLITUDE : -AMPLITUDE;
            default:          sym_val = 16'sd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        bit_cnt_d = bit_cnt_q;
        order_d   = order_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
        bit_d     = bit_q;
        sorder_d  = sorder_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (!etx_en) begin
            state_d  = IDLE;
            sample_d = 16'sd0;
            busy_d   = 1'b0;
            bit_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (istart) begin
                        state_d   = SEND;
                        lfsr_d    = SEED;
                        bit_cnt_d = 10'd0;
                        order_d   = 4'd0;
                        busy_d    = 1'b1;
                        bit_d     = SEED[9];
                    end
                end
                SEND: begin
                    if (inew_sample_trig) begin
                        sample_d = sym_val;
                        valid_d  = 1'b1;
                        sorder_d = order_q;
                        bit_d    = lfsr_q[9];
                        if (order_q == 4'd9) begin
                            order_d   = 4'd0;
                            lfsr_d    = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
                            bit_cnt_d = bit_cnt_q + 10'd1;
                            if (bit_cnt_q == LAST_BIT) begin
                                state_d = DONE;
                            end
                        end else begin
                            order_d = order_q + 4'd1;
                        end
                    end
                end
                DONE: begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    sample_d = 16'sd0;
                    bit_d    = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge ctx_clk or negedge rtx_rst_n) begin
        if (!rtx_rst_n) begin
            state_q   <= IDLE;
            lfsr_q    <= SEED;
            bit_cnt_q <= 10'd0;
            order_q   <= 4'd0;
            sample_q  <= 16'sd0;
            valid_q   <= 1'b0;
            bit_q     <= 1'b0;
            sorder_q  <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            bit_cnt_q <= bit_cnt_d;
            order_q   <= order_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            bit_q     <= bit_d;
            sorder_q  <= sorder_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign osample       = sample_q;
    assign osample_valid = valid_q;
    assign obit          = bit_q;
    assign osample_order = sorder_q;
    assign obusy         = busy_q;
    assign odone         = done_q;

endmodule
